pixel_adc_readout: RTL and testbench

- Array-side counterpart to the exposure/readout control FSM.
- Consumes the FSM's Erase, Expose, ADC, NRE_1 and NRE_2 strobes and runs the ramp-ADC code counter during conversion.
- Latches a per-pixel code when that pixel's comparator trips, then streams the stored codes row by row on a valid/ready interface to the downstream frame buffer.

---
 rtl/pixel_adc_readout.sv | 154 +++++++++++++++
 tb/tb_pixel_adc_readout.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/pixel_adc_readout.sv
// pixel_adc_readout: ramp-ADC conversion over a 2-row pixel array with row-wise valid/ready readout
module pixel_adc_readout #(
  parameter int W = 8,
  parameter int PIX_PER_ROW = 2,
  localparam int NPIX = 2 * PIX_PER_ROW,
  localparam int IW = (NPIX > 1) ? $clog2(NPIX) : 1
) (
  input  logic            clk,
  input  logic            RESET,
  input  logic            Erase,
  input  logic            Expose,
  input  logic            ADC,
  input  logic            NRE_1,
  input  logic            NRE_2,
  input  logic [NPIX-1:0] cmp,
  output logic [W-1:0]    ramp_code,
  output logic [W-1:0]    data_out,
  output logic [IW-1:0]   pix_idx,
  output logic            data_valid,
  input  logic            data_ready,
  output logic [NPIX-1:0] sat,
  output logic            rd_err
);
  typedef enum logic [1:0] {IDLE, CONVERT, READY, STREAM} state_t;
  localparam logic [W-1:0] MAX = '1;
  localparam logic [IW-1:0] LAST1 = IW'(PIX_PER_ROW - 1);
  localparam logic [IW-1:0] LAST2 = IW'(NPIX - 1);
  localparam logic [IW-1:0] FIRST2 = IW'(PIX_PER_ROW);
  state_t state_q, state_d;
  logic [W-1:0] ramp_q, ramp_d, dout_q, dout_d;
  logic [W-1:0] pix_q [NPIX];
  logic [W-1:0] pix_d [NPIX];
  logic [NPIX-1:0] lat_q, lat_d, sat_q, sat_d;
  logic [IW-1:0] idx_q, idx_d;
  logic valid_q, valid_d, rd_err_q, rd_err_d;
  logic pend1_q, pend1_d, pend2_q, pend2_d, nre1_q, nre2_q;
  logic fall1, fall2, xfer, expose_unused;
  assign expose_unused = Expose;
  assign fall1 = nre1_q & ~NRE_1;
  assign fall2 = nre2_q & ~NRE_2;
  assign xfer = valid_q & data_ready;
  always_comb begin
    state_d = state_q;
    ramp_d = ramp_q;
    dout_d = dout_q;
    pix_d = pix_q;
    lat_d = lat_q;
    sat_d = sat_q;
    idx_d = idx_q;
    valid_d = valid_q;
    rd_err_d = rd_err_q | ((fall1 | fall2) & ADC);
    // a clear on a row's last transfer loses to a same-cycle re-request, so repeats queue up
    pend1_d = (pend1_q & ~(state_q == STREAM && xfer && idx_q == LAST1)) | (fall1 & ~ADC);
    pend2_d = (pend2_q & ~(state_q == STREAM && xfer && idx_q == LAST2)) | (fall2 & ~ADC);
    case (state_q)
      IDLE: begin
        ramp_d = '0;
        if (Erase) begin
          for (int i = 0; i < NPIX; i++) pix_d[i] = '0;
          lat_d = '0;
          sat_d = '0;
          rd_err_d = 1'b0;
        end else if (ADC) begin
          state_d = CONVERT;
          lat_d = '0;
          sat_d = '0;
        end
      end
      CONVERT: begin
        if (Erase) begin
          for (int i = 0; i < NPIX; i++) pix_d[i] = '0;
          lat_d = '0;
          sat_d = '0;
          rd_err_d = 1'b0;
          ramp_d = '0;
          state_d = IDLE;
        end else if (ADC) begin
          for (int i = 0; i < NPIX; i++)
            if (!lat_q[i] && cmp[i]) begin
              pix_d[i] = ramp_q;
              lat_d[i] = 1'b1;
            end
          ramp_d = (ramp_q == MAX) ? MAX : ramp_q + 1'b1;
        end else begin
          for (int i = 0; i < NPIX; i++)
            if (!lat_q[i]) begin
              pix_d[i] = MAX;
              sat_d[i] = 1'b1;
            end
          ramp_d = '0;
          state_d = READY;
        end
      end
      READY: begin
        if (pend1_q || pend2_q) state_d = STREAM;
        else if (ADC) begin
          state_d = CONVERT;
          lat_d = '0;
          sat_d = '0;
        end
      end
      STREAM: begin
        if (!valid_q || (xfer && (idx_q == LAST1 || idx_q == LAST2))) begin
          valid_d = pend1_d | pend2_d;
          idx_d = pend1_d ? '0 : FIRST2;
          dout_d = valid_d ? pix_q[idx_d] : dout_q;
          idx_d = valid_d ? idx_d : idx_q;
          state_d = valid_d ? STREAM : READY;
        end else if (xfer) begin
          idx_d = idx_q + 1'b1;
          dout_d = pix_q[idx_d];
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      ramp_q <= '0;
      dout_q <= '0;
      for (int i = 0; i < NPIX; i++) pix_q[i] <= '0;
      lat_q <= '0;
      sat_q <= '0;
      idx_q <= '0;
      valid_q <= 1'b0;
      rd_err_q <= 1'b0;
      pend1_q <= 1'b0;
      pend2_q <= 1'b0;
      nre1_q <= 1'b1;
      nre2_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ramp_q <= ramp_d;
      dout_q <= dout_d;
      pix_q <= pix_d;
      lat_q <= lat_d;
      sat_q <= sat_d;
      idx_q <= idx_d;
      valid_q <= valid_d;
      rd_err_q <= rd_err_d;
      pend1_q <= pend1_d;
      pend2_q <= pend2_d;
      nre1_q <= NRE_1;
      nre2_q <= NRE_2;
    end
  end
  assign ramp_code = ramp_q;
  assign data_out = dout_q;
  assign pix_idx = idx_q;
  assign data_valid = valid_q;
  assign sat = sat_q;
  assign rd_err = rd_err_q;
endmodule

// File: tb/tb_pixel_adc_readout.sv
// tb_pixel_adc_readout: directed stimulus with a queue scoreboard checked by a separate output monitor
module tb_pixel_adc_readout;
  logic clk = 0, RESET = 1, Erase = 0, Expose = 0, ADC = 0, NRE_1 = 1, NRE_2 = 1;
  logic [3:0] cmp = '0;
  logic [7:0] ramp_code, data_out;
  logic [1:0] pix_idx;
  logic data_valid, data_ready = 1, rd_err;
  logic [3:0] sat;
  int checks = 0, errors = 0;
  logic [9:0] exp_q [$];
  int thr [4];
  logic conv_on = 0, glitch = 0, bp = 0, rdy_main = 1;
  int bp_cnt = 0;
  logic hold_pending = 0;
  logic [9:0] hold_val;

  pixel_adc_readout #(.W(8), .PIX_PER_ROW(2)) dut (
    .clk(clk), .RESET(RESET), .Erase(Erase), .Expose(Expose), .ADC(ADC),
    .NRE_1(NRE_1), .NRE_2(NRE_2), .cmp(cmp), .ramp_code(ramp_code),
    .data_out(data_out), .pix_idx(pix_idx), .data_valid(data_valid),
    .data_ready(data_ready), .sat(sat), .rd_err(rd_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name, output int t);
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      tick(1);
      t++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  // comparator model: trips once the observed ramp reaches each threshold
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 4; i++) cmp[i] = conv_on && thr[i] >= 0 && int'(ramp_code) >= thr[i];
    if (conv_on && glitch) cmp[0] = (ramp_code >= 10 && ramp_code < 13) || ramp_code >= 50;
  end

  always @(posedge clk) begin
    #1;
    data_ready = bp ? (bp_cnt % 4 == 0 || bp_cnt % 4 == 3) : rdy_main;
    if (bp) bp_cnt++;
  end

  always @(negedge clk) begin
    if (RESET) hold_pending = 0;
    else begin
      if (hold_pending && data_valid) chk("hold_stable", {pix_idx, data_out}, hold_val);
      hold_pending = data_valid && !data_ready;
      hold_val = {pix_idx, data_out};
      if (data_valid && data_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_xfer: got idx %0d data %0d expected none", pix_idx, data_out);
        end else chk("xfer", {pix_idx, data_out}, exp_q.pop_front());
      end
    end
  end

  initial begin
    int t;
    thr = '{-1, -1, -1, -1};
    tick(3);
    RESET = 0;
    tick(2);
    chk("rst_ramp", ramp_code, 0);
    chk("rst_valid", data_valid, 0);
    chk("rst_rd_err", rd_err, 0);
    chk("rst_sat", sat, 0);
    chk("rst_data", data_out, 0);
    chk("rst_idx", pix_idx, 0);
    thr = '{17, 40, 200, -1};
    conv_on = 1;
    Expose = 1;
    ADC = 1;
    tick(300);
    chk("ramp_sat", ramp_code, 255);
    tick(1);
    chk("ramp_hold", ramp_code, 255);
    ADC = 0;
    Expose = 0;
    tick(1);
    conv_on = 0;
    chk("close_ramp", ramp_code, 0);
    chk("close_sat", sat, 4'b1000);
    exp_q.push_back({2'd0, 8'd17});
    exp_q.push_back({2'd1, 8'd40});
    NRE_1 = 0;
    tick(1);
    NRE_1 = 1;
    drain("row1_drain", t);
    chk("row1_cycles", t, 4);
    tick(2);
    chk("row1_done", data_valid, 0);
    exp_q.push_back({2'd0, 8'd17});
    exp_q.push_back({2'd1, 8'd40});
    exp_q.push_back({2'd2, 8'd200});
    exp_q.push_back({2'd3, 8'd255});
    bp = 1;
    NRE_1 = 0;
    NRE_2 = 0;
    tick(1);
    NRE_1 = 1;
    NRE_2 = 1;
    drain("bp_drain", t);
    bp = 0;
    rdy_main = 1;
    tick(3);
    chk("bp_done", data_valid, 0);
    ADC = 1;
    tick(3);
    NRE_2 = 0;
    tick(1);
    NRE_2 = 1;
    tick(5);
    chk("err_flag", rd_err, 1);
    chk("err_nostream", data_valid, 0);
    Erase = 1;
    ADC = 0;
    tick(1);
    Erase = 0;
    tick(1);
    chk("erase_rd_err", rd_err, 0);
    chk("erase_sat", sat, 0);
    chk("erase_ramp", ramp_code, 0);
    for (int i = 0; i < 4; i++) chk("erase_pix", dut.pix_q[i], 0);
    thr = '{-1, 5, 60, 100};
    glitch = 1;
    conv_on = 1;
    ADC = 1;
    tick(120);
    ADC = 0;
    tick(1);
    conv_on = 0;
    glitch = 0;
    chk("glitch_sat", sat, 0);
    exp_q.push_back({2'd0, 8'd10});
    exp_q.push_back({2'd1, 8'd5});
    NRE_1 = 0;
    tick(1);
    NRE_1 = 1;
    drain("glitch_drain", t);
    tick(2);
    rdy_main = 0;
    tick(1);
    NRE_2 = 0;
    tick(1);
    NRE_2 = 1;
    t = 0;
    while (!data_valid && t < 20) begin
      tick(1);
      t++;
    end
    chk("pre_rst_valid", data_valid, 1);
    chk("pre_rst_pix", {pix_idx, data_out}, {2'd2, 8'd60});
    #2;
    RESET = 1;
    #1;
    chk("arst_valid", data_valid, 0);
    chk("arst_data", data_out, 0);
    chk("arst_idx", pix_idx, 0);
    chk("arst_ramp", ramp_code, 0);
    chk("arst_sat", sat, 0);
    chk("arst_rd_err", rd_err, 0);
    @(posedge clk);
    #1;
    RESET = 0;
    rdy_main = 1;
    tick(3);
    chk("post_rst_valid", data_valid, 0);
    chk("post_rst_ramp", ramp_code, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
